// File: rtl/sar_search_16b.sv
// sar_search_16b: successive-approximation search engine. Presents trial values to an
// external comparator, consumes its one-hot less/equal/greater flags and converges on
// the comparator's hidden target, finishing with a verify compare of the final value.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        begin a search (sampled only while idle)
//   o_trial        current trial value
//   o_trial_valid  trial valid, held stable until the handshake
//   i_cmp_valid    comparator flags valid; handshake when o_trial_valid & i_cmp_valid
//   i_cmp_l        target > trial
//   i_cmp_g        target == trial
//   i_cmp_m        target < trial
//   o_busy         search in progress
//   o_done         one-cycle completion pulse (success or error)
//   o_result       found value, held until the next accepted start
//   o_err          inconsistent flags seen, held until the next accepted start
module sar_search_16b #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_trial,
  output logic             o_trial_valid,
  input  logic             i_cmp_valid,
  input  logic             i_cmp_l,
  input  logic             i_cmp_g,
  input  logic             i_cmp_m,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_trial, w_trial_d;
  logic [WIDTH-1:0] r_result, w_result_d;
  logic [IdxW-1:0]  r_idx, w_idx_d;
  logic [IdxW-1:0]  w_idx_dn;
  logic             r_verify, w_verify_d;
  logic             r_err, w_err_d;
  logic             w_onehot;

  assign w_idx_dn = r_idx - IdxW'(1);

  assign w_onehot = ({i_cmp_l, i_cmp_g, i_cmp_m} == 3'b100) ||
                    ({i_cmp_l, i_cmp_g, i_cmp_m} == 3'b010) ||
                    ({i_cmp_l, i_cmp_g, i_cmp_m} == 3'b001);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_trial  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_verify <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_trial  <= w_trial_d;
      r_result <= w_result_d;
      r_idx    <= w_idx_d;
      r_verify <= w_verify_d;
      r_err    <= w_err_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_trial_d  = r_trial;
    w_result_d = r_result;
    w_idx_d    = r_idx;
    w_verify_d = r_verify;
    w_err_d    = r_err;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_trial_d            = '0;
          w_trial_d[WIDTH-1]   = 1'b1;
          w_idx_d              = IdxW'(WIDTH - 1);
          w_verify_d           = 1'b0;
          w_result_d           = '0;
          w_err_d              = 1'b0;
          w_state_d            = StReq;
        end
      end
      StReq: begin
        if (i_cmp_valid) begin
          if (!w_onehot) begin
            w_err_d    = 1'b1;
            w_result_d = r_trial;
            w_state_d  = StDone;
          end else if (i_cmp_g) begin
            w_result_d = r_trial;
            w_state_d  = StDone;
          end else if (r_verify) begin
            // Final value did not match: the comparator contradicted itself.
            w_err_d    = 1'b1;
            w_result_d = r_trial;
            w_state_d  = StDone;
          end else begin
            if (i_cmp_m) begin
              w_trial_d[r_idx] = 1'b0;
            end
            if (r_idx != '0) begin
              w_trial_d[w_idx_dn] = 1'b1;
              w_idx_d             = w_idx_dn;
            end else begin
              // All bits decided; one more compare confirms the value.
              w_verify_d = 1'b1;
            end
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_trial       = r_trial;
  assign o_trial_valid = (r_state == StReq);
  assign o_busy        = (r_state == StReq);
  assign o_done        = (r_state == StDone);
  assign o_result      = r_result;
  assign o_err         = r_err;

endmodule
